btb_bht_predictor: RTL and testbench
====================================

Name: btb_bht_predictor

Overview:
- Parametrised branch target buffer with an integrated global-history branch history table.
- Sits beside the instruction fetch unit.
- Each fetch-block lookup returns a registered prediction one cycle later (taken, slot mask, branch index, target, opaque entry id, BHT history/value).
- The execute stage trains it through a single update port.
- Generalises the fixed 4-wide / 10-bit opaque prediction response to configurable fetch width, table depth and history length.

Parameters:
- ENTRIES, 16, number of fully-associative BTB entries (power of two, >=2).
- FETCH_WIDTH, 4, instructions per fetch block (power of two); block = FETCH_WIDTH*4 bytes.
- OPAQUE_BITS, 10, width of resp_entry; holds the hit entry index zero-extended (>= clog2(ENTRIES)).
- BHT_ENTRIES, 64, number of 2-bit saturating counters (power of two).
- HISTORY_BITS, 6, global history length (<= clog2(BHT_ENTRIES)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request.
- req_addr  in  32  fetch PC; bits [1:0] ignored.
- resp_valid  out  1  response valid, exactly one cycle after req_valid.
- resp_hit  out  1  a BTB entry matched.
- resp_taken  out  1  predicted taken.
- resp_mask  out  FETCH_WIDTH  valid-instruction mask of the fetch block.
- resp_bridx  out  clog2(FETCH_WIDTH)  slot of the predicted branch.
- resp_target  out  32  predicted target.
- resp_entry  out  OPAQUE_BITS  hit entry index.
- resp_bht_history  out  HISTORY_BITS  GHR snapshot used for this lookup.
- resp_bht_value  out  2  BHT counter read.
- upd_valid  in  1  training update.
- upd_pc  in  32  PC of the resolved control-flow instruction.
- upd_target  in  32  resolved target.
- upd_is_br  in  1  1 = conditional branch, 0 = unconditional jump.
- upd_taken  in  1  resolved direction.
- upd_history  in  HISTORY_BITS  resp_bht_history returned with that instruction's prediction.
- invalidate  in  1  flush all BTB entries.

Behaviour:
- Reset (async, rst_n=0):
  - all entry valid bits 0; all BHT counters 2'b01; GHR 0; replacement pointer 0.
  - all outputs 0.
- Entry contents: valid, tag = pc[31:2], target[31:0], is_br.
- Lookup, computed from state before the clock edge and registered at the edge (1-cycle latency):
  - slot s = req_addr[2 +: clog2(FETCH_WIDTH)].
  - Candidates: valid entries in the same fetch block (tag bits above the slot field equal) with entry slot >= s.
  - Winner: lowest-slot candidate; ties are impossible because tags are unique.
  - BHT index = pc_word[clog2(BHT_ENTRIES)-1:0] XOR zero-extended GHR, where pc_word is the winner pc (or req_addr[31:2] on a miss).
  - On a hit: resp_taken = is_br ? counter[1] : 1; resp_bridx = winner slot; resp_target = stored target; resp_entry = index.
  - On a miss: resp_taken=0, resp_bridx=FETCH_WIDTH-1, resp_target=0, resp_entry=0.
  - resp_mask bit i = (i >= s) && (!resp_taken || i <= resp_bridx).
  - resp_bht_value and resp_bht_history are always reported.
  - req_valid=0: resp_valid=0 next cycle; the other response outputs hold their previous values.
- Update (upd_valid=1, applied at the clock edge):
  - CAM on upd_pc[31:2].
  - Match: if upd_taken, overwrite target; update is_br.
  - No match and upd_taken: allocate the lowest-index invalid entry. If no entry is invalid, replace entry[ptr] and increment ptr modulo ENTRIES. ptr changes only on replacement of a valid entry.
  - No match and not taken: no allocation.
  - If upd_is_br:
    - counter at index (upd_pc[2 +: clog2(BHT_ENTRIES)] XOR upd_history) saturating-increments if taken, else decrements (clamped at 0 and 3).
    - GHR <= {GHR[HISTORY_BITS-2:0], upd_taken}.
  - Jumps never touch the BHT or GHR.
- Same-cycle lookup and update: the lookup sees pre-update contents (no bypass).
- invalidate=1: all valid bits cleared at the edge. It overrides a simultaneous allocation/target write. The BHT, GHR and ptr are unaffected (BHT/GHR training from a simultaneous update still occurs). A lookup in the same cycle sees pre-invalidate contents.
- Reset mid-lookup: resp_valid drops immediately and the pending response is lost.

Test Plan:
- After reset, req 0x1000 -> resp_valid=1 next cycle, hit=0, taken=0, mask=4'b1111, bridx=3, bht_value=2'b01, history=0.
- Update jump pc=0x1008, target=0x2000, taken=1; then req 0x1000 -> hit=1, taken=1, bridx=2, mask=4'b0111, target=0x2000, entry=0. Req 0x100C -> miss, mask=4'b1000.
- Branch pc=0x1004, history=0, taken twice -> counter 01->10->11, GHR=2'b11 in low bits. Req 0x1000 with GHR=3 reads the counter at the index XOR 3. Drive three not-taken updates -> counter saturates at 00; fourth not-taken stays 00.
- Fill 16 entries with taken jumps, then a 17th new pc -> entry 0 replaced, ptr=1; an 18th replaces entry 1. Re-update an existing pc -> no allocation, ptr unchanged.
- Same-cycle update (new target 0x3000) and lookup of the same block -> response shows the old target; the next lookup shows 0x3000.
- invalidate with a simultaneous taken update of a new pc -> next lookup misses everywhere; BHT counter for that pc still trained. Assert rst_n low mid-stream -> resp_valid=0 immediately and the table is empty afterwards.

Source files
------------

// File: rtl/btb_bht_predictor.sv
// Fully-associative branch target buffer with a gshare-style branch history table.
// One lookup per cycle with a registered response; trained through a single update port.
module btb_bht_predictor #(
    parameter int ENTRIES      = 16,
    parameter int FETCH_WIDTH  = 4,
    parameter int OPAQUE_BITS  = 10,
    parameter int BHT_ENTRIES  = 64,
    parameter int HISTORY_BITS = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  logic [31:0]                    req_addr,
    output logic                           resp_valid,
    output logic                           resp_hit,
    output logic                           resp_taken,
    output logic [FETCH_WIDTH-1:0]         resp_mask,
    output logic [$clog2(FETCH_WIDTH)-1:0] resp_bridx,
    output logic [31:0]                    resp_target,
    output logic [OPAQUE_BITS-1:0]         resp_entry,
    output logic [HISTORY_BITS-1:0]        resp_bht_history,
    output logic [1:0]                     resp_bht_value,
    input  logic                           upd_valid,
    input  logic [31:0]                    upd_pc,
    input  logic [31:0]                    upd_target,
    input  logic                           upd_is_br,
    input  logic                           upd_taken,
    input  logic [HISTORY_BITS-1:0]        upd_history,
    input  logic                           invalidate
);

    localparam int SLOT_W = $clog2(FETCH_WIDTH);
    localparam int ENT_W  = $clog2(ENTRIES);
    localparam int BHT_W  = $clog2(BHT_ENTRIES);
    localparam int TAG_W  = 30;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        res = ctr;
        if (up && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!up && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

    logic [ENTRIES-1:0]      valid_q;
    logic [TAG_W-1:0]        tag_q  [ENTRIES];
    logic [31:0]             tgt_q  [ENTRIES];
    logic                    isbr_q [ENTRIES];
    logic [1:0]              bht_q  [BHT_ENTRIES];
    logic [HISTORY_BITS-1:0] ghr_q;
    logic [ENT_W-1:0]        ptr_q;

    logic                    resp_valid_q, resp_hit_q, resp_taken_q;
    logic [FETCH_WIDTH-1:0]  resp_mask_q, resp_mask_d;
    logic [SLOT_W-1:0]       resp_bridx_q;
    logic [31:0]             resp_target_q, resp_target_d;
    logic [OPAQUE_BITS-1:0]  resp_entry_q, resp_entry_d;
    logic [HISTORY_BITS-1:0] resp_hist_q;
    logic [1:0]              resp_value_q;

    logic                    unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[1:0], upd_pc[1:0]};

    logic [TAG_W-1:0]  req_word;
    logic [SLOT_W-1:0] req_slot;
    assign req_word = req_addr[31:2];
    assign req_slot = req_word[SLOT_W-1:0];

    logic              lk_hit;
    logic [ENT_W-1:0]  lk_idx;
    logic [SLOT_W-1:0] lk_slot;
    logic [BHT_W-1:0]  lk_pc_low;
    logic [BHT_W-1:0]  lk_bht_idx;
    logic [1:0]        lk_ctr;
    logic              lk_taken;

    // Lowest-slot valid entry of the fetch block at or after the requested slot.
    always_comb begin
        lk_hit  = 1'b0;
        lk_idx  = '0;
        lk_slot = '1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i]
                && tag_q[i][TAG_W-1:SLOT_W] == req_word[TAG_W-1:SLOT_W]
                && tag_q[i][SLOT_W-1:0] >= req_slot
                && (!lk_hit || tag_q[i][SLOT_W-1:0] < lk_slot)) begin
                lk_hit  = 1'b1;
                lk_idx  = ENT_W'(i);
                lk_slot = tag_q[i][SLOT_W-1:0];
            end
        end
    end

    assign lk_pc_low  = lk_hit ? tag_q[lk_idx][BHT_W-1:0] : req_word[BHT_W-1:0];
    assign lk_bht_idx = lk_pc_low ^ BHT_W'(ghr_q);
    assign lk_ctr     = bht_q[lk_bht_idx];
    assign lk_taken   = lk_hit && (!isbr_q[lk_idx] || lk_ctr[1]);

    always_comb begin
        resp_mask_d = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            resp_mask_d[i] = (SLOT_W'(i) >= req_slot) && (!lk_taken || SLOT_W'(i) <= lk_slot);
        end
    end

    assign resp_target_d = lk_hit ? tgt_q[lk_idx] : 32'h0;
    assign resp_entry_d  = lk_hit ? OPAQUE_BITS'(lk_idx) : '0;

    // Response register: only a valid request refreshes the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_taken_q  <= 1'b0;
            resp_mask_q   <= '0;
            resp_bridx_q  <= '0;
            resp_target_q <= '0;
            resp_entry_q  <= '0;
            resp_hist_q   <= '0;
            resp_value_q  <= '0;
        end else begin
            resp_valid_q <= req_valid;
            if (req_valid) begin
                resp_hit_q    <= lk_hit;
                resp_taken_q  <= lk_taken;
                resp_mask_q   <= resp_mask_d;
                resp_bridx_q  <= lk_slot;
                resp_target_q <= resp_target_d;
                resp_entry_q  <= resp_entry_d;
                resp_hist_q   <= ghr_q;
                resp_value_q  <= lk_ctr;
            end
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_hit         = resp_hit_q;
    assign resp_taken       = resp_taken_q;
    assign resp_mask        = resp_mask_q;
    assign resp_bridx       = resp_bridx_q;
    assign resp_target      = resp_target_q;
    assign resp_entry       = resp_entry_q;
    assign resp_bht_history = resp_hist_q;
    assign resp_bht_value   = resp_value_q;

    logic [TAG_W-1:0] upd_word;
    logic             up_match;
    logic [ENT_W-1:0] up_idx;
    logic             free_found;
    logic [ENT_W-1:0] free_idx;
    logic [ENT_W-1:0] alloc_idx;
    logic [ENT_W-1:0] wr_idx;
    logic             do_write, do_alloc, do_repl;
    logic [BHT_W-1:0] upd_bht_idx;

    assign upd_word = upd_pc[31:2];

    always_comb begin
        up_match = 1'b0;
        up_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == upd_word) begin
                up_match = 1'b1;
                up_idx   = ENT_W'(i);
            end
        end
    end

    // Descending scan so the lowest invalid index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = ENT_W'(i);
            end
        end
    end

    assign alloc_idx   = free_found ? free_idx : ptr_q;
    assign wr_idx      = up_match ? up_idx : alloc_idx;
    assign do_write    = upd_valid && !invalidate;
    assign do_alloc    = do_write && !up_match && upd_taken;
    assign do_repl     = do_alloc && !free_found;
    assign upd_bht_idx = upd_pc[2 +: BHT_W] ^ BHT_W'(upd_history);

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[alloc_idx] <= upd_word;
        end
        if (do_write && upd_taken) begin
            tgt_q[wr_idx] <= upd_target;
        end
        if (do_write && (up_match || upd_taken)) begin
            isbr_q[wr_idx] <= upd_is_br;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
            ghr_q   <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            if (invalidate) begin
                valid_q <= '0;
            end else if (do_alloc) begin
                valid_q[alloc_idx] <= 1'b1;
            end
            if (do_repl) begin
                ptr_q <= ptr_q + ENT_W'(1);
            end
            // Direction training happens even when the BTB write is flushed.
            if (upd_valid && upd_is_br) begin
                bht_q[upd_bht_idx] <= sat_step(bht_q[upd_bht_idx], upd_taken);
                ghr_q <= {ghr_q[HISTORY_BITS-2:0], upd_taken};
            end
        end
    end

endmodule

// File: tb/tb_btb_bht_predictor.sv
// Directed and randomized bench for btb_bht_predictor against a slot-walking reference model.
module tb_btb_bht_predictor;
    localparam int FW  = 4;
    localparam int ENT = 16;
    localparam int OB  = 10;
    localparam int BE  = 64;
    localparam int HB  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = '0;
    logic          resp_valid, resp_hit, resp_taken;
    logic [FW-1:0] resp_mask;
    logic [1:0]    resp_bridx;
    logic [31:0]   resp_target;
    logic [OB-1:0] resp_entry;
    logic [HB-1:0] resp_bht_history;
    logic [1:0]    resp_bht_value;
    logic          upd_valid = 1'b0;
    logic [31:0]   upd_pc = '0;
    logic [31:0]   upd_target = '0;
    logic          upd_is_br = 1'b0;
    logic          upd_taken = 1'b0;
    logic [HB-1:0] upd_history = '0;
    logic          invalidate = 1'b0;

    always #5 clk = ~clk;

    btb_bht_predictor #(
        .ENTRIES(ENT), .FETCH_WIDTH(FW), .OPAQUE_BITS(OB), .BHT_ENTRIES(BE), .HISTORY_BITS(HB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_taken(resp_taken),
        .resp_mask(resp_mask), .resp_bridx(resp_bridx), .resp_target(resp_target),
        .resp_entry(resp_entry), .resp_bht_history(resp_bht_history),
        .resp_bht_value(resp_bht_value),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_is_br(upd_is_br), .upd_taken(upd_taken), .upd_history(upd_history),
        .invalidate(invalidate)
    );

    int checks = 0;
    int errors = 0;

    bit          m_valid [ENT];
    logic [31:0] m_pc    [ENT];
    logic [31:0] m_tgt   [ENT];
    bit          m_isbr  [ENT];
    int          m_bht   [BE];
    int          m_ghr;
    int          m_ptr;

    logic          e_valid, e_hit, e_taken;
    logic [FW-1:0] e_mask;
    logic [1:0]    e_bridx;
    logic [31:0]   e_target;
    logic [OB-1:0] e_entry;
    logic [HB-1:0] e_hist;
    logic [1:0]    e_value;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string t);
        check({t, ".valid"},  32'(resp_valid),       32'(e_valid));
        check({t, ".hit"},    32'(resp_hit),         32'(e_hit));
        check({t, ".taken"},  32'(resp_taken),       32'(e_taken));
        check({t, ".mask"},   32'(resp_mask),        32'(e_mask));
        check({t, ".bridx"},  32'(resp_bridx),       32'(e_bridx));
        check({t, ".target"}, resp_target,           e_target);
        check({t, ".entry"},  32'(resp_entry),       32'(e_entry));
        check({t, ".hist"},   32'(resp_bht_history), 32'(e_hist));
        check({t, ".value"},  32'(resp_bht_value),   32'(e_value));
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < BE; i++) m_bht[i] = 1;
        m_ghr = 0;
        m_ptr = 0;
        e_valid = 0; e_hit = 0; e_taken = 0; e_mask = '0; e_bridx = '0;
        e_target = '0; e_entry = '0; e_hist = '0; e_value = '0;
    endtask

    // Walk the slots of the fetch block upward from the requested one; first stored pc wins.
    task automatic model_lookup(input logic [31:0] addr);
        int          s, hit_slot, hit_ent, idx;
        logic [31:0] pc, word_pc;
        s = int'(addr[3:2]);
        hit_slot = -1;
        hit_ent = -1;
        word_pc = addr;
        for (int slot = s; slot < FW && hit_slot < 0; slot++) begin
            pc = (addr & 32'hFFFF_FFF0) + 32'(slot * 4);
            for (int i = 0; i < ENT; i++) begin
                if (m_valid[i] && m_pc[i][31:2] == pc[31:2]) begin
                    hit_slot = slot;
                    hit_ent = i;
                    word_pc = pc;
                end
            end
        end
        idx = int'(word_pc[7:2]) ^ m_ghr;
        e_valid = 1'b1;
        e_hist  = 6'(m_ghr);
        e_value = 2'(m_bht[idx]);
        e_hit   = (hit_ent >= 0);
        if (e_hit) begin
            e_taken  = m_isbr[hit_ent] ? e_value[1] : 1'b1;
            e_bridx  = 2'(hit_slot);
            e_target = m_tgt[hit_ent];
            e_entry  = 10'(hit_ent);
        end else begin
            e_taken  = 1'b0;
            e_bridx  = 2'(FW - 1);
            e_target = '0;
            e_entry  = '0;
        end
        for (int i = 0; i < FW; i++) begin
            e_mask[i] = (i >= s) && (!e_taken || i <= int'(e_bridx));
        end
    endtask

    task automatic model_update(input bit uv, input logic [31:0] pc, input logic [31:0] tgt,
                                input bit br, input bit tk, input logic [HB-1:0] hist,
                                input bit inv);
        int match, slot, idx;
        if (uv) begin
            match = -1;
            for (int i = 0; i < ENT; i++) begin
                if (m_valid[i] && m_pc[i][31:2] == pc[31:2]) match = i;
            end
            if (!inv) begin
                if (match >= 0) begin
                    if (tk) m_tgt[match] = tgt;
                    m_isbr[match] = br;
                end else if (tk) begin
                    slot = -1;
                    for (int i = ENT - 1; i >= 0; i--) begin
                        if (!m_valid[i]) slot = i;
                    end
                    if (slot < 0) begin
                        slot = m_ptr;
                        m_ptr = (m_ptr + 1) % ENT;
                    end
                    m_valid[slot] = 1'b1;
                    m_pc[slot] = pc;
                    m_tgt[slot] = tgt;
                    m_isbr[slot] = br;
                end
            end
            if (br) begin
                idx = int'(pc[7:2]) ^ int'(hist);
                if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
                m_ghr = ((m_ghr << 1) | int'(tk)) & (BE - 1);
            end
        end
        if (inv) begin
            for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
        end
    endtask

    task automatic drive(input string t, input bit rv, input logic [31:0] ra, input bit uv,
                         input logic [31:0] up, input logic [31:0] ut, input bit br,
                         input bit tk, input logic [HB-1:0] uh, input bit inv);
        req_valid = rv; req_addr = ra;
        upd_valid = uv; upd_pc = up; upd_target = ut; upd_is_br = br; upd_taken = tk;
        upd_history = uh; invalidate = inv;
        if (rv) model_lookup(ra);
        else    e_valid = 1'b0;
        @(posedge clk);
        #1;
        model_update(uv, up, ut, br, tk, uh, inv);
        req_valid = 0; upd_valid = 0; invalidate = 0;
        check_resp(t);
    endtask

    task automatic lookup(input string t, input logic [31:0] a);
        drive(t, 1, a, 0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input bit br,
                          input bit tk, input logic [HB-1:0] h);
        drive("upd", 0, '0, 1, pc, tgt, br, tk, h, 0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_resp("reset");
        rst_n = 1'b1;

        lookup("cold", 32'h1000);
        check("cold.mask_c", 32'(resp_mask), 32'hF);
        check("cold.bridx_c", 32'(resp_bridx), 32'd3);
        check("cold.value_c", 32'(resp_bht_value), 32'd1);

        update(32'h1008, 32'h2000, 0, 1, '0);
        lookup("jmp", 32'h1000);
        check("jmp.mask_c", 32'(resp_mask), 32'h7);
        check("jmp.target_c", resp_target, 32'h2000);
        check("jmp.bridx_c", 32'(resp_bridx), 32'd2);
        lookup("past", 32'h100C);
        check("past.mask_c", 32'(resp_mask), 32'h8);
        check("past.hit_c", 32'(resp_hit), 32'd0);

        update(32'h1004, 32'h1800, 1, 1, '0);
        update(32'h1004, 32'h1800, 1, 1, '0);
        lookup("br_ghr3", 32'h1000);
        lookup("ctr_sat_hi", 32'h2008);
        check("ctr_sat_hi.value_c", 32'(resp_bht_value), 32'd3);
        for (int k = 0; k < 4; k++) update(32'h1004, 32'h1800, 1, 0, '0);
        lookup("ctr_sat_lo", 32'h20C4);
        check("ctr_sat_lo.value_c", 32'(resp_bht_value), 32'd0);

        for (int k = 0; k < 14; k++) update(32'h3000 + 32'(4 * k), 32'h8000 + 32'(k), 0, 1, '0);
        update(32'h4000, 32'hA000, 0, 1, '0);
        lookup("repl0", 32'h4000);
        check("repl0.entry_c", 32'(resp_entry), 32'd0);
        lookup("evicted", 32'h1008);
        update(32'h4010, 32'hA010, 0, 1, '0);
        lookup("repl1", 32'h4010);
        check("repl1.entry_c", 32'(resp_entry), 32'd1);
        update(32'h3004, 32'h5555_0000, 0, 1, '0);
        update(32'h4020, 32'hA020, 0, 1, '0);
        lookup("repl2", 32'h4020);
        check("repl2.entry_c", 32'(resp_entry), 32'd2);

        drive("same_cyc", 1, 32'h3004, 1, 32'h3004, 32'h3000, 0, 1, '0, 0);
        check("same_cyc.old_c", resp_target, 32'h5555_0000);
        lookup("after_upd", 32'h3004);
        check("after_upd.new_c", resp_target, 32'h3000);

        drive("inval", 0, '0, 1, 32'h6000, 32'h7000, 1, 1, '0, 1);
        lookup("inv_a", 32'h1000);
        lookup("inv_b", 32'h3000);
        lookup("inv_c", 32'h4000);
        lookup("inv_d", 32'h6000);
        lookup("inv_bht", 32'h6084);
        check("inv_bht.value_c", 32'(resp_bht_value), 32'd2);

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst.valid", 32'(resp_valid), 32'd0);
        check_resp("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lookup("post_rst_a", 32'h1000);
        lookup("post_rst_b", 32'h4000);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra, up, ut;
            bit rv, uv, br, tk, inv;
            logic [HB-1:0] uh;
            rv  = ($urandom_range(0, 3) != 0);
            uv  = ($urandom_range(0, 1) != 0);
            ra  = 32'h1000 + 32'($urandom_range(0, 31)) * 32'd4;
            up  = 32'h1000 + 32'($urandom_range(0, 31)) * 32'd4;
            ut  = $urandom;
            br  = ($urandom_range(0, 1) != 0);
            tk  = ($urandom_range(0, 2) != 0);
            uh  = 6'($urandom);
            inv = ($urandom_range(0, 49) == 0);
            drive("rand", rv, ra, uv, up, ut, br, tk, uh, inv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
